// File: rtl/mcbsp_pkg.sv
// mcbsp_pkg: shared widths, state encoding and word-length clamp for the McBSP slave link.
package mcbsp_pkg;
  localparam int MCBSP_WORD_W = 32;
  localparam int MCBSP_LEN_W = 7;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic [5:0] eff_len(input logic [MCBSP_LEN_W-1:0] len);
    return (len == '0 || len > 7'd32) ? 6'd32 : len[5:0];
  endfunction
endpackage

// File: rtl/mcbsp_slaver_tx_if.sv
// mcbsp_slaver_tx_if: frame, serial and producer-side signals of the slave transmitter.
interface mcbsp_slaver_tx_if;
  import mcbsp_pkg::*;
  logic [MCBSP_LEN_W-1:0] mcbsp_reg_length;
  logic mcbsp_slaver_fsr;
  logic mcbsp_slaver_miso;
  logic mcbsp_slaver_oe;
  logic [MCBSP_WORD_W-1:0] mcbsp_data_in;
  logic mcbsp_vaild_in;
  logic mcbsp_ready_out;
  logic [4:0] mcbsp_fifo_level;
  logic mcbsp_tx_done;
  logic mcbsp_underrun;
  logic mcbsp_frame_err;
  logic [63:0] debug_signal;
  modport slave (
    input mcbsp_reg_length, mcbsp_slaver_fsr, mcbsp_data_in, mcbsp_vaild_in,
    output mcbsp_slaver_miso, mcbsp_slaver_oe, mcbsp_ready_out, mcbsp_fifo_level,
    output mcbsp_tx_done, mcbsp_underrun, mcbsp_frame_err, debug_signal
  );
  modport master (
    output mcbsp_reg_length, mcbsp_slaver_fsr, mcbsp_data_in, mcbsp_vaild_in,
    input mcbsp_slaver_miso, mcbsp_slaver_oe, mcbsp_ready_out, mcbsp_fifo_level,
    input mcbsp_tx_done, mcbsp_underrun, mcbsp_frame_err, debug_signal
  );
endinterface

// File: rtl/mcbsp_tx_fifo.sv
// mcbsp_tx_fifo: single-clock word FIFO; push/pop are ignored when full/empty respectively.
module mcbsp_tx_fifo
  import mcbsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [MCBSP_WORD_W-1:0] din,
  output logic [MCBSP_WORD_W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [4:0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [MCBSP_WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == 5'(FIFO_DEPTH);
  assign empty = level == 5'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + 5'(do_push) - 5'(do_pop);
    end
endmodule

// File: rtl/mcbsp_slaver_tx.sv
// mcbsp_slaver_tx: shifts buffered words MSB-first to the DSP on DSP-supplied clock and frame sync.
module mcbsp_slaver_tx
  import mcbsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input logic mcbsp_slaver_clkr,
  input logic mcbsp_slaver_rst_n,
  mcbsp_slaver_tx_if.slave bus
);
  state_t state;
  logic [4:0] cnt;
  logic [MCBSP_WORD_W-1:0] shreg, head, word;
  logic full, empty, fsr;
  logic [5:0] n, nm1;
  assign fsr = bus.mcbsp_slaver_fsr;
  assign n = eff_len(bus.mcbsp_reg_length);
  assign nm1 = n - 6'd1;
  assign word = empty ? IDLE_WORD : head;
  assign bus.mcbsp_ready_out = !full;
  mcbsp_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(mcbsp_slaver_clkr),
    .rst_n(mcbsp_slaver_rst_n),
    .push(bus.mcbsp_vaild_in),
    .pop(fsr),
    .din(bus.mcbsp_data_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(bus.mcbsp_fifo_level)
  );
  // Any fsr starts a frame; the N=1 case passes through SHIFT with cnt=0 for its single bit.
  always_ff @(posedge mcbsp_slaver_clkr or negedge mcbsp_slaver_rst_n)
    if (!mcbsp_slaver_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      bus.mcbsp_slaver_miso <= 1'b0;
      bus.mcbsp_slaver_oe <= 1'b0;
      bus.mcbsp_tx_done <= 1'b0;
      bus.mcbsp_underrun <= 1'b0;
      bus.mcbsp_frame_err <= 1'b0;
    end else begin
      bus.mcbsp_tx_done <= 1'b0;
      bus.mcbsp_underrun <= 1'b0;
      bus.mcbsp_frame_err <= 1'b0;
      if (fsr) begin
        state <= SHIFT;
        shreg <= word;
        cnt <= nm1[4:0];
        bus.mcbsp_slaver_miso <= word[nm1[4:0]];
        bus.mcbsp_slaver_oe <= 1'b1;
        bus.mcbsp_tx_done <= n == 6'd1;
        bus.mcbsp_underrun <= empty;
        bus.mcbsp_frame_err <= state == SHIFT && cnt != 5'd0;
      end else if (state == SHIFT && cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
        bus.mcbsp_slaver_miso <= shreg[cnt-5'd1];
        bus.mcbsp_tx_done <= cnt == 5'd1;
      end else begin
        state <= IDLE;
        bus.mcbsp_slaver_miso <= 1'b0;
        bus.mcbsp_slaver_oe <= 1'b0;
      end
    end
  assign bus.debug_signal = {16'd0, state == SHIFT, cnt, shreg, bus.mcbsp_fifo_level,
                             bus.mcbsp_tx_done, bus.mcbsp_underrun, bus.mcbsp_frame_err,
                             bus.mcbsp_slaver_oe, bus.mcbsp_slaver_miso};
endmodule

// File: tb/tb_mcbsp_slaver_tx.sv
// tb_mcbsp_slaver_tx: directed stimulus with a bit-level scoreboard of expected miso/tx_done.
module tb_mcbsp_slaver_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncomp = 0;
  int nfail = 0;
  bit q[$];
  mcbsp_slaver_tx_if bus ();
  mcbsp_slaver_tx #(.FIFO_DEPTH(4), .IDLE_WORD(32'hFFFF_0000)) dut (
    .mcbsp_slaver_clkr(clk),
    .mcbsp_slaver_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Bits leave the scoreboard in the order the DUT drives them, one per oe-high clock.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.mcbsp_slaver_oe) begin
        if (q.size() == 0) chk("oe_extra", 1, 0);
        else begin
          chk("miso", bus.mcbsp_slaver_miso, q.pop_front());
          chk("tx_done", bus.mcbsp_tx_done, q.size() == 0);
        end
      end else if (q.size() != 0) chk("oe_low", 0, 1);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_word(input logic [31:0] w);
    bus.mcbsp_vaild_in = 1'b1;
    bus.mcbsp_data_in = w;
    tick();
    bus.mcbsp_vaild_in = 1'b0;
  endtask
  task automatic frame(input logic [31:0] w, input int n);
    bus.mcbsp_slaver_fsr = 1'b1;
    for (int i = n - 1; i >= 0; i--) q.push_back(w[i]);
    tick();
    bus.mcbsp_slaver_fsr = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || bus.mcbsp_slaver_oe) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      chk("idle_timeout", 0, 1);
      q.delete();
    end
  endtask
  initial begin
    bus.mcbsp_reg_length = 7'd32;
    bus.mcbsp_slaver_fsr = 1'b0;
    bus.mcbsp_data_in = '0;
    bus.mcbsp_vaild_in = 1'b0;
    #22;
    chk("rst_miso", bus.mcbsp_slaver_miso, 0);
    chk("rst_oe", bus.mcbsp_slaver_oe, 0);
    chk("rst_ready", bus.mcbsp_ready_out, 1);
    chk("rst_level", bus.mcbsp_fifo_level, 0);
    chk("rst_flags", {bus.mcbsp_tx_done, bus.mcbsp_underrun, bus.mcbsp_frame_err}, 0);
    rst_n = 1'b1;
    tick();
    push_word(32'hA5A5_0F0F);
    chk("t1_level1", bus.mcbsp_fifo_level, 1);
    frame(32'hA5A5_0F0F, 32);
    chk("t1_level0", bus.mcbsp_fifo_level, 0);
    chk("t1_underrun", bus.mcbsp_underrun, 0);
    wait_idle();
    bus.mcbsp_reg_length = 7'd8;
    push_word(32'h0000_00C3);
    push_word(32'h0000_003C);
    chk("t2_level2", bus.mcbsp_fifo_level, 2);
    frame(32'h0000_00C3, 8);
    chk("t2_ferr_a", bus.mcbsp_frame_err, 0);
    repeat (7) tick();
    frame(32'h0000_003C, 8);
    chk("t2_ferr_b", bus.mcbsp_frame_err, 0);
    chk("t2_level0", bus.mcbsp_fifo_level, 0);
    wait_idle();
    bus.mcbsp_reg_length = 7'd0;
    frame(32'hFFFF_0000, 32);
    chk("t3_underrun", bus.mcbsp_underrun, 1);
    tick();
    chk("t3_underrun_pulse", bus.mcbsp_underrun, 0);
    wait_idle();
    bus.mcbsp_reg_length = 7'd8;
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    chk("t4_ready3", bus.mcbsp_ready_out, 1);
    push_word(32'h44);
    chk("t4_ready_full", bus.mcbsp_ready_out, 0);
    chk("t4_level4", bus.mcbsp_fifo_level, 4);
    push_word(32'h55);
    chk("t4_level_drop", bus.mcbsp_fifo_level, 4);
    frame(32'h11, 8);
    wait_idle();
    frame(32'h22, 8);
    wait_idle();
    frame(32'h33, 8);
    wait_idle();
    frame(32'h44, 8);
    chk("t4_underrun", bus.mcbsp_underrun, 0);
    wait_idle();
    chk("t4_empty", bus.mcbsp_fifo_level, 0);
    bus.mcbsp_reg_length = 7'd1;
    push_word(32'h1);
    frame(32'h1, 1);
    chk("t7_len1_done", bus.mcbsp_tx_done, 1);
    tick();
    chk("t7_len1_oe", bus.mcbsp_slaver_oe, 0);
    bus.mcbsp_reg_length = 7'd32;
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    frame(32'h1234_5678, 32);
    bus.mcbsp_reg_length = 7'd4;
    chk("t5_level1", bus.mcbsp_fifo_level, 1);
    repeat (9) tick();
    bus.mcbsp_reg_length = 7'd32;
    q.delete();
    frame(32'h9ABC_DEF0, 32);
    chk("t5_frame_err", bus.mcbsp_frame_err, 1);
    chk("t5_level0", bus.mcbsp_fifo_level, 0);
    tick();
    chk("t5_ferr_pulse", bus.mcbsp_frame_err, 0);
    wait_idle();
    push_word(32'hDEAD_BEEF);
    frame(32'hDEAD_BEEF, 32);
    repeat (4) tick();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("t6_miso", bus.mcbsp_slaver_miso, 0);
    chk("t6_oe", bus.mcbsp_slaver_oe, 0);
    chk("t6_level", bus.mcbsp_fifo_level, 0);
    chk("t6_ready", bus.mcbsp_ready_out, 1);
    tick();
    rst_n = 1'b1;
    tick();
    frame(32'hFFFF_0000, 32);
    chk("t6_underrun", bus.mcbsp_underrun, 1);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
